// File: rtl/sn_gen_array.sv
`default_nettype none
// ============================================================================
// Module   : sn_gen_array
// Brief    : Multi-channel stochastic number generator. One shared Fibonacci
//            LFSR feeds CH comparators. Each channel sees its own rotation of
//            the LFSR state. A small sequencer emits LEN samples per START
//            and then pulses DONE.
// Revision : 1.0 - initial release
// ============================================================================
module sn_gen_array #(
    parameter int WIDTH = 32,
    parameter int CH    = 4,
    parameter int LEN_W = 16,
    localparam int AW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic             START,
    input  logic             ABORT,
    input  logic [LEN_W-1:0] LEN,
    input  logic             MODE,
    input  logic             SEED_WE,
    input  logic [WIDTH-1:0] SEED,
    input  logic             THR_WE,
    input  logic [AW-1:0]    THR_ADDR,
    input  logic [WIDTH-1:0] THR_DATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             SN_VALID,
    output logic [CH-1:0]    SN_OUT_P,
    output logic [CH-1:0]    SN_OUT_N
);

    // Feedback tap masks for each legal width, kept 32 bits wide and trimmed.
    localparam logic [31:0] TAPS32 = (WIDTH == 8)  ? 32'h0000_00B8 :
                                     (WIDTH == 16) ? 32'h0000_D008 :
                                     (WIDTH == 24) ? 32'h00E1_0000 :
                                                     32'h8020_0003;
    localparam logic [WIDTH-1:0] TAP_MASK = TAPS32[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] ONE_L    = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam int               SLICE    = WIDTH / CH;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               done_q, done_d;
    logic               valid_q, valid_d;
    logic [CH-1:0]      p_q, p_d;
    logic [CH-1:0]      n_q, n_d;
    logic [WIDTH-1:0]   thr_q [CH];

    logic [WIDTH-1:0]   lfsr_next;
    logic [2*WIDTH-1:0] lfsr_dbl;
    logic [CH-1:0]      cmp_p;
    logic [CH-1:0]      cmp_n;

    assign lfsr_next = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAP_MASK)};
    assign lfsr_dbl  = {lfsr_q, lfsr_q};

    // Per-channel comparator on a rotated view of the shared LFSR.
    for (genvar c = 0; c < CH; c++) begin : g_ch
        localparam int SH = c * SLICE;
        logic [WIDTH-1:0] rot;
        logic [WIDTH-1:0] mag;
        logic [WIDTH-1:0] qv;
        logic             neg;
        logic             lt_uni;
        logic             lt_bip;

        assign rot    = lfsr_dbl[2*WIDTH-1-SH -: WIDTH];
        assign neg    = thr_q[c][WIDTH-1];
        // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
        assign mag    = neg ? ((~thr_q[c]) + ONE_W) : thr_q[c];
        assign qv     = {1'b0, rot[WIDTH-2:0]};
        assign lt_uni = (rot < thr_q[c]);
        assign lt_bip = (qv < mag);
        assign cmp_p[c] = mode_q ? (~neg & lt_bip) : lt_uni;
        assign cmp_n[c] = mode_q & neg & lt_bip;
    end

    // Threshold bank: writable in any state, out-of-range addresses match no entry.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int c = 0; c < CH; c++) thr_q[c] <= '0;
        end else if (THR_WE) begin
            for (int c = 0; c < CH; c++) begin
                if (THR_ADDR == AW'(c)) thr_q[c] <= THR_DATA;
            end
        end
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            p_q     <= '0;
            n_q     <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            p_q     <= p_d;
            n_q     <= n_d;
        end
    end

    // Next-state logic: seed/start handling in IDLE, sampling and abort in RUN.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        valid_d = 1'b0;
        p_d     = '0;
        n_d     = '0;
        case (state_q)
            S_IDLE: begin
                // A zero seed would lock the LFSR, so it is replaced by 1.
                if (SEED_WE) lfsr_d = (SEED == '0) ? ONE_W : SEED;
                if (START) begin
                    if (LEN == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        cnt_d   = LEN;
                        mode_d  = MODE;
                    end
                end
            end
            S_RUN: begin
                if (ABORT) begin
                    // Abort beats the final sample; the LFSR keeps its state.
                    state_d = S_IDLE;
                end else begin
                    valid_d = 1'b1;
                    p_d     = cmp_p;
                    n_d     = cmp_n;
                    lfsr_d  = lfsr_next;
                    cnt_d   = cnt_q - ONE_L;
                    if (cnt_q == ONE_L) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign BUSY     = (state_q == S_RUN);
    assign DONE     = done_q;
    assign SN_VALID = valid_q;
    assign SN_OUT_P = p_q;
    assign SN_OUT_N = n_q;

endmodule
`default_nettype wire

// File: tb/tb_sn_gen_array.sv
`default_nettype none
// ============================================================================
// Module   : tb_sn_gen_array
// Brief    : Scoreboard bench for sn_gen_array (WIDTH=32, CH=4). The stimulus
//            thread predicts every sample from a reference model and queues
//            it; a negedge monitor pops and compares whenever SN_VALID is up.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sn_gen_array;

    localparam int W  = 32;
    localparam int CH = 4;
    localparam int LW = 16;

    logic          CLK = 1'b0;
    logic          RST_X = 1'b0;
    logic          START = 1'b0;
    logic          ABORT = 1'b0;
    logic [LW-1:0] LEN = '0;
    logic          MODE = 1'b0;
    logic          SEED_WE = 1'b0;
    logic [W-1:0]  SEED = '0;
    logic          THR_WE = 1'b0;
    logic [1:0]    THR_ADDR = '0;
    logic [W-1:0]  THR_DATA = '0;
    logic          BUSY;
    logic          DONE;
    logic          SN_VALID;
    logic [CH-1:0] SN_OUT_P;
    logic [CH-1:0] SN_OUT_N;

    sn_gen_array #(.WIDTH(W), .CH(CH), .LEN_W(LW)) dut (
        .CLK(CLK), .RST_X(RST_X), .START(START), .ABORT(ABORT), .LEN(LEN),
        .MODE(MODE), .SEED_WE(SEED_WE), .SEED(SEED), .THR_WE(THR_WE),
        .THR_ADDR(THR_ADDR), .THR_DATA(THR_DATA), .BUSY(BUSY), .DONE(DONE),
        .SN_VALID(SN_VALID), .SN_OUT_P(SN_OUT_P), .SN_OUT_N(SN_OUT_N)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [CH-1:0] p;
        logic [CH-1:0] n;
        logic          last;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          lone_done = 0;
    bit          mon_en = 1'b0;
    logic [31:0] m_lfsr;
    logic [31:0] m_thr [CH];
    int          st_p0, st_agree, st_p1, st_n1, st_n2;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_range(input string nm, input int v, input int lo, input int hi);
        total++;
        if (v < lo || v > hi) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d..%0d", nm, v, lo, hi);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        if (s == 0) return v;
        return (v << s) | (v >> (32 - s));
    endfunction

    // Reference: per-channel rule applied to the current model LFSR and thresholds.
    function automatic exp_t model_sample(input bit mode);
        exp_t        e;
        logic [31:0] r;
        longint      t, mag, qv;
        e = '0;
        for (int c = 0; c < CH; c++) begin
            r   = rotl(m_lfsr, c * (W / CH));
            t   = longint'($signed(m_thr[c]));
            mag = (t < 0) ? -t : t;
            qv  = longint'(r & 32'h7FFF_FFFF);
            if (!mode)       e.p[c] = (r < m_thr[c]);
            else if (t >= 0) e.p[c] = (qv < mag);
            else             e.n[c] = (qv < mag);
        end
        return e;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], v[31] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    // Monitor: every valid sample must match the head of the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        if (mon_en) begin
            if (SN_VALID) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: got SN_VALID=1, expected 0");
                end else begin
                    e = sb.pop_front();
                    chk("sn_out_p", 64'(SN_OUT_P), 64'(e.p));
                    chk("sn_out_n", 64'(SN_OUT_N), 64'(e.n));
                    chk("done_with_last", 64'(DONE), 64'(e.last));
                    st_p0    += int'(SN_OUT_P[0]);
                    st_agree += int'(SN_OUT_P[0] == SN_OUT_P[1]);
                    st_p1    += int'(SN_OUT_P[1]);
                    st_n1    += int'(SN_OUT_N[1]);
                    st_n2    += int'(SN_OUT_N[2]);
                end
            end else begin
                chk("idle_outputs_zero", 64'({SN_OUT_P, SN_OUT_N}), 64'd0);
                if (DONE) begin
                    total++;
                    if (lone_done > 0) lone_done--;
                    else begin
                        bad++;
                        $display("FAIL unexpected_done: got DONE=1, expected 0");
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic wthr(input logic [1:0] a, input logic [31:0] d);
        THR_WE = 1'b1; THR_ADDR = a; THR_DATA = d; m_thr[a] = d;
        tick;
        THR_WE = 1'b0;
    endtask

    task automatic wseed(input logic [31:0] v);
        SEED_WE = 1'b1; SEED = v; m_lfsr = (v == 0) ? 32'd1 : v;
        tick;
        SEED_WE = 1'b0;
    endtask

    task automatic clr_stats;
        st_p0 = 0; st_agree = 0; st_p1 = 0; st_n1 = 0; st_n2 = 0;
    endtask

    // One run: optional abort at cycle abort_k, threshold write at thr_k,
    // ignored seed write at seed_k, optional seed load together with START.
    task automatic run(input int len, input bit mode, input int abort_k, input int thr_k,
                       input int seed_k, input bit seed_en, input logic [31:0] sv);
        int   busy_n;
        exp_t e;
        logic [1:0] a;
        busy_n = 0;
        START = 1'b1; LEN = LW'(len); MODE = mode;
        if (seed_en) begin
            SEED_WE = 1'b1; SEED = sv; m_lfsr = (sv == 0) ? 32'd1 : sv;
        end
        if (len == 0) lone_done++;
        tick;
        START = 1'b0; SEED_WE = 1'b0;
        for (int k = 0; k < len; k++) begin
            busy_n += int'(BUSY);
            if (k == abort_k) begin
                ABORT = 1'b1;
                tick;
                ABORT = 1'b0;
                break;
            end
            e = model_sample(mode);
            e.last = (k == len - 1);
            sb.push_back(e);
            m_lfsr = lfsr_step(m_lfsr);
            if (k == thr_k) begin
                a = 2'($urandom_range(0, CH - 1));
                THR_WE = 1'b1; THR_ADDR = a; THR_DATA = $urandom; m_thr[a] = THR_DATA;
            end
            if (k == seed_k) begin
                SEED_WE = 1'b1; SEED = $urandom;
            end
            tick;
            THR_WE = 1'b0; SEED_WE = 1'b0;
        end
        for (int i = 0; i < 10 && (sb.size() != 0 || lone_done != 0); i++) tick;
        chk("scoreboard_drained", 64'(sb.size() + lone_done), 64'd0);
        chk("busy_low_after_run", 64'(BUSY), 64'd0);
        if (abort_k < 0 && len > 0) chk("busy_cycles", 64'(busy_n), 64'(len));
    endtask

    initial begin
        m_lfsr = '0;
        for (int c = 0; c < CH; c++) m_thr[c] = '0;
        clr_stats();

        // Reset state
        repeat (3) tick;
        chk("reset_busy", 64'(BUSY), 64'd0);
        chk("reset_done", 64'(DONE), 64'd0);
        chk("reset_valid", 64'(SN_VALID), 64'd0);
        chk("reset_pn", 64'({SN_OUT_P, SN_OUT_N}), 64'd0);
        RST_X = 1'b1;
        tick;
        mon_en = 1'b1;

        // Seed 1, thr0 all ones, three samples
        wseed(32'h0000_0001);
        wthr(2'd0, 32'hFFFF_FFFF);
        run(3, 1'b0, -1, -1, -1, 1'b0, '0);

        // All thresholds zero: no ones at all
        for (int c = 0; c < CH; c++) wthr(2'(c), 32'd0);
        run(16, 1'b0, -1, -1, -1, 1'b0, '0);

        // Unipolar statistics
        wseed(32'h0000_ACE1);
        wthr(2'd0, 32'h8000_0000);
        wthr(2'd1, 32'h8000_0000);
        clr_stats();
        run(4096, 1'b0, -1, -1, -1, 1'b0, '0);
        chk_range("popcount_p0", st_p0, 2048 - 128, 2048 + 128);
        chk_range("agree_p0_p1", st_agree, 2048 - 160, 2048 + 160);

        // Bipolar statistics
        wthr(2'd1, 32'hC000_0000);
        wthr(2'd2, 32'h8000_0000);
        clr_stats();
        run(4096, 1'b1, -1, -1, -1, 1'b0, '0);
        chk("bipolar_p1_zero", 64'(st_p1), 64'd0);
        chk_range("bipolar_n1_pop", st_n1, 2048 - 128, 2048 + 128);
        chk("bipolar_n2_all", 64'(st_n2), 64'd4096);

        // Abort in the 5th valid cycle, then continue from the held LFSR
        wthr(2'd0, $urandom);
        wthr(2'd3, $urandom);
        run(10, 1'b0, 5, -1, -1, 1'b0, '0);
        chk("abort_valid_low", 64'(SN_VALID), 64'd0);
        run(2, 1'b0, -1, -1, -1, 1'b0, '0);

        // Zero-length run: lone DONE pulse
        run(0, 1'b0, -1, -1, -1, 1'b0, '0);

        // Zero seed, seed with START, seed write during RUN, mid-run threshold write
        wseed(32'h0000_0000);
        run(5, 1'b0, -1, -1, -1, 1'b0, '0);
        run(12, 1'b1, -1, 4, 2, 1'b1, $urandom);

        // Randomised runs
        repeat (8) begin
            for (int c = 0; c < CH; c++) wthr(2'(c), $urandom);
            run($urandom_range(1, 40), 1'($urandom_range(0, 1)), -1,
                $urandom_range(0, 40), $urandom_range(0, 40),
                1'($urandom_range(0, 1)), $urandom);
        end

        // Asynchronous reset in the middle of a run
        mon_en = 1'b0;
        wthr(2'd0, 32'hFFFF_FFFF);
        wseed(32'h1234_5678);
        START = 1'b1; LEN = 16'd20; MODE = 1'b0;
        tick;
        START = 1'b0;
        repeat (4) tick;
        #2 RST_X = 1'b0;
        #1;
        chk("midrun_reset_busy", 64'(BUSY), 64'd0);
        chk("midrun_reset_valid", 64'(SN_VALID), 64'd0);
        chk("midrun_reset_done", 64'(DONE), 64'd0);
        chk("midrun_reset_pn", 64'({SN_OUT_P, SN_OUT_N}), 64'd0);
        tick;
        RST_X = 1'b1;
        sb.delete();
        lone_done = 0;
        m_lfsr = '0;
        for (int c = 0; c < CH; c++) m_thr[c] = '0;
        tick;
        mon_en = 1'b1;
        // Only thr0 rewritten; zero LFSR and cleared thresholds must show up.
        wthr(2'd0, 32'hFFFF_FFFF);
        run(4, 1'b0, -1, -1, -1, 1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sn_gen_array.md
Name: sn_gen_array

Overview:
- Multi-channel, width-parametrised stochastic number generator with a built-in run sequencer.
- One shared Fibonacci LFSR drives CH comparators. Each channel sees a different rotation of the LFSR state to decorrelate its stream.
- After START, the block emits exactly LEN bit-parallel SN samples, then pulses DONE.
- Sits between the host register interface (seeds and thresholds) and the SN arithmetic datapath.

Parameters:
- WIDTH, 32, LFSR and threshold width; legal values 8, 16, 24, 32.
- CH, 4, number of output channels; WIDTH % CH must equal 0.
- LEN_W, 16, width of the bitstream length counter.

Ports:
- CLK  in  1  clock
- RST_X  in  1  asynchronous active-low reset
- START  in  1  request a run of LEN samples
- ABORT  in  1  terminate the current run immediately
- LEN  in  LEN_W  number of samples; sampled on START acceptance
- MODE  in  1  0 = unipolar, 1 = bipolar; latched on START acceptance
- SEED_WE  in  1  load SEED into the LFSR
- SEED  in  WIDTH  LFSR seed
- THR_WE  in  1  write THR_DATA to threshold[THR_ADDR]
- THR_ADDR  in  max(1,$clog2(CH))  channel index
- THR_DATA  in  WIDTH  threshold value
- BUSY  out  1  high while the FSM is in RUN
- DONE  out  1  one-cycle end-of-run pulse
- SN_VALID  out  1  SN_OUT_P/N hold a valid sample this cycle
- SN_OUT_P  out  CH  positive stream bits
- SN_OUT_N  out  CH  negative stream bits

Behaviour:
- Reset values:
  - All outputs 0, LFSR 0, all thresholds 0, length counter 0, latched mode 0, FSM in IDLE.
  - Reset is honoured mid-run: everything returns to these values, no DONE.
- LFSR:
  - Shifts left; feedback bit enters at bit 0.
  - Feedback is the XOR of these tap bits:
    - WIDTH=8: bits 7,5,4,3.
    - WIDTH=16: bits 15,14,12,3.
    - WIDTH=24: bits 23,22,21,16.
    - WIDTH=32: bits 31,21,1,0.
  - Advances exactly once per RUN cycle; otherwise holds.
- Seed load:
  - SEED_WE is accepted only in IDLE; it is ignored in RUN.
  - SEED=0 loads 1 instead (no lock-up).
  - SEED_WE and START in the same IDLE cycle: the seed loads, and the run starts with the new seed.
- Thresholds:
  - THR_WE is accepted in any state. The new value is used from the next cycle's comparison.
  - An out-of-range THR_ADDR (≥ CH) is ignored.
- Channel c value: r_c = LFSR rotated left by c*(WIDTH/CH).
- Unipolar mode (MODE=0):
  - P = (r_c < thr_c), unsigned.
  - N = 0.
- Bipolar mode (MODE=1), thr_c is two's complement:
  - m = |thr_c|, as a WIDTH-bit unsigned value; the most negative value gives m = 2^(WIDTH-1).
  - q = r_c[WIDTH-2:0], zero-extended.
  - thr_c ≥ 0: P = (q < m), N = 0.
  - thr_c < 0: P = 0, N = (q < m).
- FSM states and transitions:
  - IDLE, START, LEN>0: latch LEN and MODE, counter ← LEN, go to RUN, BUSY=1 from the next cycle.
  - IDLE, START, LEN=0: stay in IDLE; DONE pulses the next cycle; SN_VALID stays 0.
  - RUN, every cycle: compare the current LFSR against the thresholds and register the result into SN_OUT_P/N; SN_VALID ← 1; LFSR advances; counter decrements.
  - RUN with counter==1: go to IDLE; DONE ← 1 in the same registered cycle as the final SN_VALID.
  - RUN, ABORT: go to IDLE next edge; no DONE; SN_VALID ← 0; LFSR holds its current state. ABORT wins over counter==1.
  - START while in RUN is ignored; ABORT while in IDLE is ignored.
- Timing:
  - START is sampled at edge t0.
  - SN_VALID is high after edges t1..tLEN: LEN consecutive cycles.
  - Sample k (0-based) is the comparison of the LFSR state after k shifts from the seed.
  - DONE and BUSY deassert behaviour both follow the tLEN edge.
- Outputs when not valid: SN_OUT_P/N are forced to 0 whenever SN_VALID=0.

Test Plan:
- WIDTH=32, CH=4, seed 0x00000001, thr0=0xFFFFFFFF, START LEN=3:
  - LFSR sequence 0x1, 0x3, 0x6.
  - SN_OUT_P[0]=1,1,1; SN_VALID high 3 cycles; DONE coincides with the 3rd.
- Unipolar, thr=0 on all channels, LEN=16: all P=0 and N=0; SN_VALID high 16 cycles; BUSY high 16 cycles.
- Unipolar, thr0=0x80000000, LEN=4096, seed 0xACE1:
  - popcount(P[0]) within 2048±128.
  - Channel pairs (0,1): agreement count within 2048±160 (decorrelated).
- Bipolar:
  - thr1=0xC0000000 (−2^30): P[1]=0 throughout; popcount(N[1]) ≈ 2048±128 over 4096.
  - thr2=0x80000000: N[2]=1 every sample.
- Boundary and abort:
  - ABORT at the 5th valid cycle of a LEN=10 run: SN_VALID drops after that edge, no DONE, BUSY=0.
  - Next START LEN=2 continues from the held LFSR state.
  - START with LEN=0: one DONE pulse, zero SN_VALID.
- Control conflicts:
  - SEED=0 loads 0x1.
  - SEED_WE during RUN leaves the sequence unchanged.
  - A THR_WE mid-run changes the comparison from the following sample.
  - Asserting RST_X low mid-run clears all outputs asynchronously.
